// File: rtl/stack_prog_driver_if.sv
// Host/CPU-side bundle for stack_prog_driver: loader and start inputs,
// CPU drive outputs and run status.
interface stack_prog_driver_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic [ADDR_W:0]   prog_len;
  logic [3:0]        nib_out;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instr_cnt;

  modport master (
    output start, wr_en, wr_addr, wr_data, prog_len,
    input  nib_out, cpu_rst, busy, done, err, pc, instr_cnt
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, prog_len,
    output nib_out, cpu_rst, busy, done, err, pc, instr_cnt
  );
endinterface

// File: rtl/stack_prog_driver.sv
// Sequences a nibble program from a small RAM into stack_cpu: opcode on the
// fetch cycle, operand held for the opcode's execute window, plus CPU reset.
//
// state | meaning
// IDLE  | CPU held in reset, waiting for start
// PRIME | one reset cycle before the first fetch
// FETCH | opcode nibble driven to the CPU
// EXEC  | operand (or 0) held for the opcode's execute window
// HALT  | program finished; CPU runs NOOPs, outputs preserved
module stack_prog_driver #(
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  stack_prog_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam int              DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W:0] PC_ONE = 1;
  localparam logic [ADDR_W:0] PC_TWO = 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [3:0] ram [DEPTH];

  state_t          state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      nib_q, nib_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      icnt_q, icnt_d;

  logic [3:0]      cur_op;
  logic [3:0]      cur_opnd;
  logic [ADDR_W:0] pc_nxt;
  logic [7:0]      icnt_inc;

  function automatic logic has_operand(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
  endfunction

  // Cycles the CPU spends after the fetch cycle for each opcode.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    logic [1:0] e;
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: e = 2'd2;
      4'h9, 4'hA:                         e = 2'd3;
      default:                            e = 2'd1;
    endcase
    return e;
  endfunction

  // The RAM cannot change while busy, so the opcode at pc stays valid in EXEC.
  assign cur_op   = ram[pc_q[ADDR_W-1:0]];
  assign cur_opnd = ram[pc_q[ADDR_W-1:0] + ADDR_ONE];
  assign pc_nxt   = pc_q + (has_operand(cur_op) ? PC_TWO : PC_ONE);
  assign icnt_inc = (icnt_q == 8'hFF) ? icnt_q : icnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    icnt_d    = icnt_q;
    nib_d     = 4'h0;
    cpu_rst_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        cpu_rst_d = (state_q == S_IDLE);
        if (bus.start) begin
          state_d   = S_PRIME;
          len_d     = bus.prog_len;
          pc_d      = '0;
          err_d     = 1'b0;
          icnt_d    = 8'd0;
          cpu_rst_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_PRIME: begin
        if (len_q != '0) begin
          state_d = S_FETCH;
          nib_d   = cur_op;
          icnt_d  = icnt_inc;
          busy_d  = 1'b1;
        end else begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
      end
      S_FETCH: begin
        // Opcode already went out; a missing operand just ends the run.
        if (has_operand(cur_op) && ((pc_q + PC_ONE) >= len_q)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
          done_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
          cnt_d   = exec_len(cur_op);
          nib_d   = has_operand(cur_op) ? cur_opnd : 4'h0;
          busy_d  = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == 2'd1) begin
          pc_d = pc_nxt;
          if (pc_nxt < len_q) begin
            state_d = S_FETCH;
            nib_d   = ram[pc_nxt[ADDR_W-1:0]];
            icnt_d  = icnt_inc;
            busy_d  = 1'b1;
          end else begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 2'd1;
          nib_d  = nib_q;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      cnt_q     <= 2'd0;
      nib_q     <= 4'h0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      icnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      nib_q     <= nib_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      icnt_q    <= icnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && ((state_q == S_IDLE) || (state_q == S_HALT))) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.nib_out   = nib_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pc        = pc_q[ADDR_W-1:0];
  assign bus.instr_cnt = icnt_q;

endmodule

// File: tb/tb_stack_prog_driver.sv
// Cycle-trace checker for stack_prog_driver: each program's expected output
// sequence is derived from the program listing and compared every cycle.
module tb_stack_prog_driver;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [3:0] nib;
    logic       crst;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] pc;
    logic [7:0] ic;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_prog_driver_if #(.ADDR_W(ADDR_W)) bus ();

  stack_prog_driver #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   mram [DEPTH];
  obs_t exp_q [$];

  function automatic obs_t mk(input int nib, input bit r, input bit b,
                              input bit d, input bit e, input int pc, input int ic);
    obs_t m;
    m.nib  = 4'(nib);
    m.crst = r;
    m.busy = b;
    m.done = d;
    m.err  = e;
    m.pc   = 5'(pc % DEPTH);
    m.ic   = 8'(ic);
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.nib  = bus.nib_out;
    o.crst = bus.cpu_rst;
    o.busy = bus.busy;
    o.done = bus.done;
    o.err  = bus.err;
    o.pc   = bus.pc;
    o.ic   = bus.instr_cnt;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected trace from the cycle after start: PRIME, then per instruction one
  // fetch cycle plus E execute cycles, then the HALT entry and a few idle HALT cycles.
  task automatic build_trace(input int len);
    int  pc, ic, opv, ew;
    bit  er, has;
    exp_q.delete();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    pc = 0; ic = 0; er = 0;
    while (pc < len) begin
      opv = mram[pc];
      ic  = (ic < 255) ? ic + 1 : 255;
      exp_q.push_back(mk(opv, 0, 1, 0, 0, pc, ic));
      has = (opv == 1) || (opv == 6) || (opv == 7) || (opv == 8);
      if (has && (pc + 1 >= len)) begin
        er = 1;
        break;
      end
      if (opv == 9 || opv == 10) ew = 3;
      else if (opv == 1 || opv == 2 || (opv >= 5 && opv <= 8)) ew = 2;
      else ew = 1;
      for (int k = 0; k < ew; k++)
        exp_q.push_back(mk(has ? mram[pc + 1] : 0, 0, 1, 0, 0, pc, ic));
      pc += has ? 2 : 1;
    end
    exp_q.push_back(mk(0, 0, 0, 1, er, pc, ic));
    for (int k = 0; k < 3; k++)
      exp_q.push_back(mk(0, 0, 0, 0, er, pc, ic));
  endtask

  task automatic load(input int vals[$]);
    foreach (vals[k]) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(k);
      bus.wr_data = 4'(vals[k]);
      mram[k]     = vals[k] & 15;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // inj >= 0 drives a write to address 1 plus a start during that trace cycle.
  task automatic run_prog(input int len, input string tag, input int inj);
    build_trace(len);
    @(negedge clk);
    bus.prog_len = 6'(len);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(tag, exp_q[i]);
      bus.wr_en   = (i == inj);
      bus.start   = (i == inj);
      bus.wr_addr = 5'd1;
      bus.wr_data = 4'hA;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    int   prog [$];
    int   len;
    obs_t idle_v;

    bus.start    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = 4'h0;
    bus.prog_len = '0;
    foreach (mram[k]) mram[k] = 0;
    idle_v = mk(0, 1, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_state", idle_v);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", idle_v);

    prog = '{1, 5, 3};
    load(prog);
    run_prog(3, "push_outl", -1);

    prog = '{1, 3, 1, 4, 9, 3};
    load(prog);
    run_prog(6, "mult_window", -1);
    assert (bus.instr_cnt === 8'd4) else begin
      n_err++;
      $error("FAIL mult_instr_cnt observed=%0d expected=4", bus.instr_cnt);
    end
    n_vec++;

    prog = '{8};
    load(prog);
    run_prog(1, "trunc_operand", -1);

    run_prog(0, "empty_prog", -1);

    prog = '{1, 5, 3};
    load(prog);
    run_prog(3, "busy_lockout", 2);
    run_prog(3, "lockout_rerun", -1);

    // Reset during the PUSH execute window, then rst and start together.
    @(negedge clk);
    bus.prog_len = 6'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_exec", mk(5, 0, 1, 0, 0, 0, 1));
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_exec", idle_v);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", idle_v);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_after_mid_reset", idle_v);

    for (int r = 0; r < 20; r++) begin
      prog.delete();
      for (int k = 0; k < DEPTH; k++) prog.push_back(int'($urandom_range(0, 15)));
      load(prog);
      len = (r == 0) ? DEPTH : int'($urandom_range(0, DEPTH));
      run_prog(len, "random_prog", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
